// File: rtl/srl_fifo_pkg.sv
// Shared constants and occupancy next-state helper for the SRL16 FIFO.
package srl_fifo_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 5;

  // Occupancy plus SRL tap address (always count-1, pinned to 0 when empty).
  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr;
  } occ_t;

  // Next count/tap address from current count and accepted push/pop.
  function automatic occ_t next_occ(input logic [CNT_W-1:0] count,
                                    input logic             push,
                                    input logic             pop);
    occ_t r;
    r.count = count;
    case ({push, pop})
      2'b10:   r.count = count + CNT_W'(1);
      2'b01:   r.count = count - CNT_W'(1);
      default: r.count = count;
    endcase
    r.addr = (r.count == '0) ? '0 : ADDR_W'(r.count - CNT_W'(1));
    return r;
  endfunction

endpackage

// File: rtl/srl16_fifo_mem.sv
// SRL16E-style storage: one 16-deep shift register per data bit, shared CE and tap.
module srl16_fifo_mem
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_srl
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // New bit enters tap 0 on every enabled cycle.
    always_comb begin
      sr_d = sr_q;
      if (ce) sr_d = {sr_q[DEPTH-2:0], d[i]};
    end

    // Storage has no reset, matching the primitive.
    always_ff @(posedge clk) begin
      sr_q <= sr_d;
    end

    // Addressable tap output.
    always_comb begin
      q[i] = sr_q[addr];
    end
  end

endmodule

// File: rtl/srl16_fifo.sv
// First-word-fall-through FIFO control around SRL16 storage.
module srl16_fifo
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S_VALID,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             S_READY,
  output logic             M_VALID,
  output logic [WIDTH-1:0] M_DATA,
  input  logic             M_READY,
  output logic [4:0]       COUNT,
  output logic             ALMOST_FULL,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              m_valid_q, m_valid_d;
  logic              s_ready_q, s_ready_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_c, pop_c;
  occ_t              occ_d;

  // Handshakes, occupancy update and flag next-state.
  always_comb begin
    pop_c     = m_valid_q & M_READY;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    push_c    = S_VALID & (s_ready_q | pop_c);
    occ_d     = next_occ(count_q, push_c, pop_c);
    m_valid_d = (occ_d.count != '0);
    s_ready_d = (occ_d.count != CNT_W'(DEPTH));
    afull_d   = (occ_d.count >= CNT_W'(AFULL_LVL));
    ovf_d     = ovf_q | (S_VALID & ~s_ready_q & ~pop_c);
    unf_d     = unf_q | (M_READY & ~m_valid_q);
  end

  // Control registers; reset wins over any same-cycle push or pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q   <= '0;
      addr_q    <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      count_q   <= occ_d.count;
      addr_q    <= occ_d.addr;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  srl16_fifo_mem #(.WIDTH(WIDTH)) u_mem (
    .clk  (CLK),
    .ce   (push_c),
    .addr (addr_q),
    .d    (S_DATA),
    .q    (M_DATA)
  );

  assign S_READY     = s_ready_q;
  assign M_VALID     = m_valid_q;
  assign COUNT       = count_q;
  assign ALMOST_FULL = afull_q;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = unf_q;

endmodule

// File: tb/tb_srl16_fifo.sv
// Directed self-checking bench for srl16_fifo.
module tb_srl16_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic       S_VALID;
  logic [7:0] S_DATA;
  logic       S_READY;
  logic       M_VALID;
  logic [7:0] M_DATA;
  logic       M_READY;
  logic [4:0] COUNT;
  logic       ALMOST_FULL;
  logic       OVERFLOW;
  logic       UNDERFLOW;

  int checks = 0;
  int errors = 0;

  srl16_fifo #(.WIDTH(8), .AFULL_LVL(12)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .S_VALID     (S_VALID),
    .S_DATA      (S_DATA),
    .S_READY     (S_READY),
    .M_VALID     (M_VALID),
    .M_DATA      (M_DATA),
    .M_READY     (M_READY),
    .COUNT       (COUNT),
    .ALMOST_FULL (ALMOST_FULL),
    .OVERFLOW    (OVERFLOW),
    .UNDERFLOW   (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    S_VALID = 1'b0;
    M_READY = 1'b0;
    S_DATA  = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (COUNT !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", COUNT); end
    checks++;
    if (M_VALID !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", M_VALID); end
    checks++;
    if (S_READY !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", S_READY); end
    checks++;
    if ({ALMOST_FULL, OVERFLOW, UNDERFLOW} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {ALMOST_FULL, OVERFLOW, UNDERFLOW});
    end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      S_VALID = 1'b1; S_DATA = vals[i];
      tick();
      checks++;
      if (COUNT !== 5'(i + 1)) begin errors++; $display("FAIL basic_push_count got %0d exp %0d", COUNT, i + 1); end
      checks++;
      if (M_VALID !== 1'b1 || M_DATA !== 8'h11) begin
        errors++; $display("FAIL basic_head got v=%b d=%h exp v=1 d=11", M_VALID, M_DATA);
      end
    end
    idle();
    M_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (M_DATA !== vals[i]) begin errors++; $display("FAIL basic_pop_data got %h exp %h", M_DATA, vals[i]); end
      tick();
      checks++;
      if (COUNT !== 5'(2 - i)) begin errors++; $display("FAIL basic_pop_count got %0d exp %0d", COUNT, 2 - i); end
      checks++;
      if (M_VALID !== (i != 2)) begin errors++; $display("FAIL basic_m_valid got %b exp %b", M_VALID, i != 2); end
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      S_VALID = 1'b1; S_DATA = 8'(i);
      tick();
      checks++;
      if (COUNT !== 5'(i + 1)) begin errors++; $display("FAIL full_count got %0d exp %0d", COUNT, i + 1); end
      checks++;
      if (ALMOST_FULL !== (i + 1 >= 12)) begin
        errors++; $display("FAIL full_afull at count %0d got %b exp %b", i + 1, ALMOST_FULL, i + 1 >= 12);
      end
    end
    checks++;
    if (S_READY !== 1'b0) begin errors++; $display("FAIL full_s_ready got %b exp 0", S_READY); end
    // Write attempt while full and not reading.
    S_VALID = 1'b1; S_DATA = 8'hFF; M_READY = 1'b0;
    tick();
    checks++;
    if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL full_overflow got %b exp 1", OVERFLOW); end
    checks++;
    if (COUNT !== 5'd16) begin errors++; $display("FAIL full_ovf_count got %0d exp 16", COUNT); end
    checks++;
    if (M_DATA !== 8'h00) begin errors++; $display("FAIL full_head got %h exp 00", M_DATA); end
    // Simultaneous push and pop at full.
    S_VALID = 1'b1; S_DATA = 8'hA5; M_READY = 1'b1;
    tick();
    checks++;
    if (COUNT !== 5'd16) begin errors++; $display("FAIL full_pp_count got %0d exp 16", COUNT); end
    checks++;
    if (M_DATA !== 8'h01) begin errors++; $display("FAIL full_pp_head got %h exp 01", M_DATA); end
    S_VALID = 1'b0;
    M_READY = 1'b1;
    for (int i = 1; i < 17; i++) begin
      checks++;
      if (M_DATA !== ((i == 16) ? 8'hA5 : 8'(i))) begin
        errors++; $display("FAIL full_drain idx %0d got %h exp %h", i, M_DATA, (i == 16) ? 8'hA5 : 8'(i));
      end
      tick();
    end
    checks++;
    if (COUNT !== 5'd0 || M_VALID !== 1'b0) begin
      errors++; $display("FAIL full_drained got count=%0d v=%b exp 0 0", COUNT, M_VALID);
    end
    idle();
  endtask

  task automatic test_stream(input int occ);
    int bad = 0;
    do_reset();
    for (int i = 0; i < occ; i++) begin
      S_VALID = 1'b1; S_DATA = 8'(i);
      tick();
    end
    M_READY = 1'b1;
    for (int k = 0; k < 100; k++) begin
      S_DATA = 8'(occ + k);
      checks++;
      if (M_VALID !== 1'b1 || M_DATA !== 8'(k)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL stream%0d_data cyc %0d got v=%b d=%h exp v=1 d=%h", occ, k, M_VALID, M_DATA, 8'(k));
      end
      tick();
      checks++;
      if (COUNT !== 5'(occ)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL stream%0d_count cyc %0d got %0d exp %0d", occ, k, COUNT, occ);
      end
    end
    idle();
  endtask

  task automatic test_underflow();
    do_reset();
    M_READY = 1'b1;
    tick();
    checks++;
    if (UNDERFLOW !== 1'b1) begin errors++; $display("FAIL unf_set got %b exp 1", UNDERFLOW); end
    checks++;
    if (COUNT !== 5'd0) begin errors++; $display("FAIL unf_count got %0d exp 0", COUNT); end
    M_READY = 1'b0; S_VALID = 1'b1; S_DATA = 8'h77;
    tick();
    idle();
    tick();
    checks++;
    if (UNDERFLOW !== 1'b1 || COUNT !== 5'd1) begin
      errors++; $display("FAIL unf_sticky got unf=%b count=%0d exp 1 1", UNDERFLOW, COUNT);
    end
  endtask

  // Continues from the single word left by test_underflow.
  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      S_VALID = 1'b1; S_DATA = 8'(8'hC0 + i);
      tick();
    end
    checks++;
    if (COUNT !== 5'd7) begin errors++; $display("FAIL rmid_pre_count got %0d exp 7", COUNT); end
    S_VALID = 1'b1; S_DATA = 8'hEE; RST = 1'b1;
    tick();
    RST = 1'b0; S_VALID = 1'b0;
    checks++;
    if (COUNT !== 5'd0 || M_VALID !== 1'b0 || S_READY !== 1'b1) begin
      errors++; $display("FAIL rmid_state got count=%0d v=%b r=%b exp 0 0 1", COUNT, M_VALID, S_READY);
    end
    checks++;
    if ({ALMOST_FULL, OVERFLOW, UNDERFLOW} !== 3'b000) begin
      errors++; $display("FAIL rmid_flags got %b exp 000", {ALMOST_FULL, OVERFLOW, UNDERFLOW});
    end
    S_VALID = 1'b1; S_DATA = 8'h5A;
    tick();
    idle();
    checks++;
    if (M_VALID !== 1'b1 || M_DATA !== 8'h5A || COUNT !== 5'd1) begin
      errors++; $display("FAIL rmid_fresh got v=%b d=%h count=%0d exp 1 5a 1", M_VALID, M_DATA, COUNT);
    end
  endtask

  initial begin
    RST = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_full();
    test_stream(1);
    test_stream(8);
    test_underflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
